// File: rtl/ibex_counter_bank.sv
// Bank of independent event counters with 32-bit windowed writes, a shadow
// snapshot of every channel, and sticky overflow flags feeding one interrupt.
module ibex_counter_bank #(
  parameter int NumCounters  = 4,
  parameter int CounterWidth = 40,
  parameter bit OvfIrqEn     = 1'b1,
  localparam int IdxW        = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumCounters-1:0] event_i,
  input  logic [NumCounters-1:0] inhibit_i,
  input  logic [IdxW-1:0]        sel_i,
  input  logic                   we_lo_i,
  input  logic                   we_hi_i,
  input  logic [31:0]            wdata_i,
  input  logic                   snap_i,
  input  logic                   rd_snap_i,
  output logic [63:0]            rdata_o,
  input  logic [NumCounters-1:0] ovf_clr_i,
  output logic [NumCounters-1:0] ovf_o,
  output logic                   irq_o
);

  localparam bit Wide = (CounterWidth > 32);

  logic [NumCounters-1:0][CounterWidth-1:0] cnt_q, cnt_d;
  logic [NumCounters-1:0][CounterWidth-1:0] shadow_q;
  logic [NumCounters-1:0]                   ovf_q, ovf_d;

  logic sel_valid;
  logic write_en;

  assign sel_valid = (32'(sel_i) < 32'(NumCounters));

  // A high-half write only exists when there are implemented bits above 31;
  // on narrow counters it is a no-op and also masks a simultaneous low write.
  assign write_en = (we_hi_i && Wide) || (we_lo_i && !we_hi_i);

  for (genvar g = 0; g < NumCounters; g++) begin : g_ch
    logic [CounterWidth-1:0] lo_val;
    logic [CounterWidth-1:0] hi_val;
    logic                    wr;
    logic                    inc;
    logic                    wrap;

    if (Wide) begin : g_wide
      assign lo_val = {cnt_q[g][CounterWidth-1:32], wdata_i};
      assign hi_val = {wdata_i[CounterWidth-33:0], cnt_q[g][31:0]};
    end else begin : g_narrow
      assign lo_val = wdata_i[CounterWidth-1:0];
      assign hi_val = cnt_q[g];
    end

    assign wr   = write_en && sel_valid && (sel_i == IdxW'(g));
    assign inc  = event_i[g] && !inhibit_i[g] && !wr;
    assign wrap = inc && (&cnt_q[g]);

    assign cnt_d[g] = wr  ? ((we_hi_i && Wide) ? hi_val : lo_val) :
                      inc ? cnt_q[g] + CounterWidth'(1) :
                            cnt_q[g];

    // A wrap on the same edge as a clear keeps the flag set.
    assign ovf_d[g] = wrap || (ovf_q[g] && !ovf_clr_i[g]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      ovf_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (snap_i) begin
        shadow_q <= cnt_q;
      end
    end
  end

  logic [CounterWidth-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (sel_i == IdxW'(i)) begin
        rd_val = rd_snap_i ? shadow_q[i] : cnt_q[i];
      end
    end
  end

  assign rdata_o = sel_valid ? 64'(rd_val) : 64'd0;
  assign ovf_o   = ovf_q;
  assign irq_o   = OvfIrqEn ? (|ovf_q) : 1'b0;

  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

endmodule

// File: tb/tb_ibex_counter_bank.sv
// Directed and randomized checks of ibex_counter_bank against a value-level
// model; a second small instance covers narrow counters and invalid selects.
`timescale 1ns/10ps
module tb_ibex_counter_bank;

  localparam int NC = 4;
  localparam int CW = 40;
  localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [NC-1:0] event_i, inhibit_i, ovf_clr_i, ovf_o;
  logic [1:0]    sel_i;
  logic          we_lo_i, we_hi_i, snap_i, rd_snap_i, irq_o;
  logic [31:0]   wdata_i;
  logic [63:0]   rdata_o;

  logic [2:0]  s_event, s_inhibit, s_ovf_clr, s_ovf;
  logic [1:0]  s_sel;
  logic        s_we_lo, s_we_hi, s_snap, s_rd_snap, s_irq;
  logic [31:0] s_wdata;
  logic [63:0] s_rdata;

  ibex_counter_bank #(.NumCounters(NC), .CounterWidth(CW), .OvfIrqEn(1'b1)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .event_i(event_i), .inhibit_i(inhibit_i),
    .sel_i(sel_i), .we_lo_i(we_lo_i), .we_hi_i(we_hi_i), .wdata_i(wdata_i),
    .snap_i(snap_i), .rd_snap_i(rd_snap_i), .rdata_o(rdata_o),
    .ovf_clr_i(ovf_clr_i), .ovf_o(ovf_o), .irq_o(irq_o)
  );

  ibex_counter_bank #(.NumCounters(3), .CounterWidth(8), .OvfIrqEn(1'b0)) u_small (
    .clk_i(clk_i), .rst_ni(rst_ni), .event_i(s_event), .inhibit_i(s_inhibit),
    .sel_i(s_sel), .we_lo_i(s_we_lo), .we_hi_i(s_we_hi), .wdata_i(s_wdata),
    .snap_i(s_snap), .rd_snap_i(s_rd_snap), .rdata_o(s_rdata),
    .ovf_clr_i(s_ovf_clr), .ovf_o(s_ovf), .irq_o(s_irq)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0]   m_cnt [NC];
  logic [63:0]   m_sh  [NC];
  logic [NC-1:0] m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 64'd0;
      m_sh[i]  = 64'd0;
    end
    m_ovf = '0;
  endtask

  // Value-level view of one clock edge, computed from the pre-edge inputs.
  task automatic model_edge();
    logic [63:0] old [NC];
    old = m_cnt;
    for (int i = 0; i < NC; i++) begin
      bit wrap;
      wrap = 1'b0;
      if ((int'(sel_i) == i) && (we_lo_i || we_hi_i)) begin
        if (we_hi_i) m_cnt[i] = (old[i] & 64'hFFFF_FFFF) | ((64'(wdata_i) << 32) & MASK);
        else         m_cnt[i] = (old[i] & MASK & ~64'hFFFF_FFFF) | 64'(wdata_i);
      end else if (event_i[i] && !inhibit_i[i]) begin
        if (old[i] == MASK) begin
          m_cnt[i] = 64'd0;
          wrap = 1'b1;
        end else begin
          m_cnt[i] = old[i] + 64'd1;
        end
      end
      if (wrap)              m_ovf[i] = 1'b1;
      else if (ovf_clr_i[i]) m_ovf[i] = 1'b0;
      if (snap_i) m_sh[i] = old[i];
    end
  endtask

  task automatic tick();
    if (rst_ni) model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [1:0] sv_sel;
    logic       sv_rd;
    sv_sel = sel_i;
    sv_rd  = rd_snap_i;
    for (int i = 0; i < NC; i++) begin
      sel_i = 2'(i);
      rd_snap_i = 1'b0;
      #0.1;
      check($sformatf("%s_live%0d", tag, i), rdata_o, m_cnt[i]);
      rd_snap_i = 1'b1;
      #0.1;
      check($sformatf("%s_shadow%0d", tag, i), rdata_o, m_sh[i]);
    end
    sel_i = sv_sel;
    rd_snap_i = sv_rd;
    check($sformatf("%s_ovf", tag), 64'(ovf_o), 64'(m_ovf));
    check($sformatf("%s_irq", tag), 64'(irq_o), 64'(|m_ovf));
  endtask

  task automatic idle();
    event_i = '0; inhibit_i = '0; ovf_clr_i = '0; sel_i = '0;
    we_lo_i = 1'b0; we_hi_i = 1'b0; snap_i = 1'b0; rd_snap_i = 1'b0; wdata_i = '0;
  endtask

  task automatic write(input logic [1:0] ch, input bit hi, input logic [31:0] data);
    sel_i = ch; we_lo_i = !hi; we_hi_i = hi; wdata_i = data;
    tick();
    we_lo_i = 1'b0; we_hi_i = 1'b0;
  endtask

  initial begin
    model_reset();
    s_event = '0; s_inhibit = '0; s_ovf_clr = '0; s_sel = '0;
    s_we_lo = 1'b0; s_we_hi = 1'b0; s_snap = 1'b0; s_rd_snap = 1'b0; s_wdata = '0;

    // Everything active while held in reset: nothing may change.
    idle();
    event_i = '1; we_lo_i = 1'b1; wdata_i = 32'h1234; snap_i = 1'b1; sel_i = 2'd1;
    repeat (3) tick();
    check_all("reset_hold");
    idle();
    rst_ni = 1'b1;

    repeat (10) begin event_i = 4'b0100; tick(); end
    event_i = '0;
    check_all("ten_events");

    write(2'd1, 1'b0, 32'hFFFF_FFFF);
    write(2'd1, 1'b1, 32'h0000_00FF);
    check_all("ch1_allones");
    event_i = 4'b0010; tick(); event_i = '0;
    check_all("ch1_wrap");
    ovf_clr_i = 4'b0010; tick(); ovf_clr_i = '0;
    check_all("ch1_clr");

    write(2'd1, 1'b0, 32'hFFFF_FFFF);
    write(2'd1, 1'b1, 32'h0000_00FF);
    event_i = 4'b0010; ovf_clr_i = 4'b0010; tick(); idle();
    check_all("wrap_beats_clr");

    sel_i = 2'd2; we_lo_i = 1'b1; we_hi_i = 1'b1; wdata_i = 32'hA5; tick(); idle();
    check_all("both_we_hi_wins");

    write(2'd0, 1'b0, 32'd5);
    event_i = 4'b1001; sel_i = 2'd0; we_lo_i = 1'b1; wdata_i = 32'd100; tick(); idle();
    check_all("write_beats_inc");

    write(2'd3, 1'b1, 32'd0);
    write(2'd3, 1'b0, 32'd7);
    snap_i = 1'b1; tick(); snap_i = 1'b0;
    repeat (3) begin event_i = 4'b1000; tick(); end
    event_i = '0;
    check_all("snap_then_count");

    repeat (5) begin event_i = 4'b0001; inhibit_i = 4'b0001; tick(); end
    idle();
    check_all("inhibit");

    for (int n = 0; n < 300; n++) begin
      int r;
      event_i   = 4'($urandom);
      inhibit_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      ovf_clr_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      snap_i    = ($urandom_range(0, 7) == 0);
      sel_i     = 2'($urandom);
      r = $urandom_range(0, 9);
      we_lo_i = (r == 0) || (r == 2);
      we_hi_i = (r == 1) || (r == 2);
      case ($urandom_range(0, 2))
        0:       wdata_i = $urandom;
        1:       wdata_i = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: wdata_i = 32'h0000_00FF;
      endcase
      tick();
      check_all($sformatf("rand%0d", n));
    end
    idle();

    s_sel = 2'd0; s_we_lo = 1'b1; s_wdata = 32'h1FF; tick(); s_we_lo = 1'b0;
    check("small_lo_trunc", s_rdata, 64'hFF);
    s_we_hi = 1'b1; s_wdata = 32'h12; tick(); s_we_hi = 1'b0;
    check("small_hi_noop", s_rdata, 64'hFF);
    s_sel = 2'd3; s_we_lo = 1'b1; s_wdata = 32'h55; tick(); s_we_lo = 1'b0;
    check("small_badsel_rd", s_rdata, 64'd0);
    s_sel = 2'd1; #0.1;
    check("small_badsel_ch1", s_rdata, 64'd0);
    s_sel = 2'd2; #0.1;
    check("small_badsel_ch2", s_rdata, 64'd0);
    s_sel = 2'd0; s_event = 3'b001; tick(); s_event = '0;
    check("small_wrap_val", s_rdata, 64'd0);
    check("small_wrap_ovf", 64'(s_ovf), 64'd1);
    check("small_irq_off", 64'(s_irq), 64'd0);

    write(2'd0, 1'b1, 32'd0);
    write(2'd0, 1'b0, 32'd20);
    write(2'd1, 1'b0, 32'hFFFF_FFFF);
    write(2'd1, 1'b1, 32'h0000_00FF);
    event_i = 4'b0011; tick(); idle();
    check_all("pre_reset");
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    check("small_async_reset", 64'(s_ovf), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
